// File: rtl/spike_packet_scheduler_pkg.sv
// Shared types and constants for the spike packet scheduler: FSM encoding,
// packet layout and default geometry.
package spike_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  localparam int DEFAULT_ADDR_W     = 12;
  localparam int DEFAULT_MAX_FANOUT = 3;
  localparam int DROP_W             = 8;

  // Packet is {origin, destination}; slots are in units of ADDR_W bits.
  localparam int PKT_DST_SLOT  = 0;
  localparam int PKT_ORIG_SLOT = 1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_packet_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from the top index back to zero.
module rr_arbiter
  import spike_packet_scheduler_pkg::*;
#(
  parameter int N     = 10,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packet_scheduler.sv
// Latches spike events per neuron, picks one source round-robin and emits one
// {origin, destination} packet per downstream target over a valid/ready port.
module spike_packet_scheduler
  import spike_packet_scheduler_pkg::*;
#(
  parameter int N_NEURONS  = 10,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int MAX_FANOUT = DEFAULT_MAX_FANOUT
) (
  input  logic                               CLK,
  input  logic                               clear,
  input  logic [N_NEURONS-1:0]               spike,
  input  logic [N_NEURONS*ADDR_W-1:0]        neuron_addresses,
  input  logic [N_NEURONS*MAX_FANOUT*ADDR_W-1:0] downstream_table,
  input  logic [N_NEURONS*2-1:0]             fanout_count,
  output logic [2*ADDR_W-1:0]                packet,
  output logic                               packet_valid,
  input  logic                               packet_ready,
  output logic                               busy,
  output logic [DROP_W-1:0]                  drop_count,
  output sched_state_e                       dbg_state_o
);

  // Handshake: packet/packet_valid are registered and held until an edge with
  // packet_valid && packet_ready; that edge completes exactly one transfer.

  localparam int IDX_W = clog2_min1(N_NEURONS);
  localparam int DST_W = clog2_min1(MAX_FANOUT);

  sched_state_e             state_q, state_d;
  logic [N_NEURONS-1:0]     pending_q, pending_d;
  logic [N_NEURONS-1:0]     grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DST_W-1:0]         dest_idx_q, dest_idx_d;
  logic [2*ADDR_W-1:0]      packet_q, packet_d;
  logic                     packet_valid_q, packet_valid_d;
  logic [DROP_W-1:0]        drop_count_q, drop_count_d;

  logic [ADDR_W-1:0] addr_arr [N_NEURONS];
  logic [ADDR_W-1:0] dst_arr  [N_NEURONS][MAX_FANOUT];
  logic [1:0]        fc_arr   [N_NEURONS];

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_unpack
    assign addr_arr[g] = neuron_addresses[g*ADDR_W +: ADDR_W];
    assign fc_arr[g]   = fanout_count[g*2 +: 2];
    for (genvar h = 0; h < MAX_FANOUT; h++) begin : g_dst
      assign dst_arr[g][h] = downstream_table[(g*MAX_FANOUT+h)*ADDR_W +: ADDR_W];
    end
  end

  logic [N_NEURONS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N(N_NEURONS), .IDX_W(IDX_W)) u_arb (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  logic [IDX_W-1:0]     cur_idx;
  logic [DST_W-1:0]     next_dest;
  logic [2*ADDR_W-1:0]  next_pkt;
  logic [N_NEURONS-1:0] release_mask;
  int                   fc_cur;
  int                   drops;

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    grant_oh_d     = grant_oh_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    dest_idx_d     = dest_idx_q;
    packet_d       = packet_q;
    packet_valid_d = packet_valid_q;
    drop_count_d   = drop_count_q;
    release_mask   = '0;
    drops          = 0;

    // In IDLE the packet is built for the neuron about to be granted.
    cur_idx = (state_q == IDLE) ? arb_idx : grant_q;
    fc_cur  = int'(fc_arr[cur_idx]);
    if (fc_cur > MAX_FANOUT) fc_cur = MAX_FANOUT;
    next_dest = (state_q == IDLE) ? '0 : dest_idx_q + 1'b1;
    if (int'(next_dest) >= MAX_FANOUT) next_dest = '0;
    next_pkt = '0;
    next_pkt[PKT_ORIG_SLOT*ADDR_W +: ADDR_W] = addr_arr[cur_idx];
    next_pkt[PKT_DST_SLOT*ADDR_W +: ADDR_W]  = dst_arr[cur_idx][next_dest];

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d        = arb_idx;
          grant_oh_d     = arb_grant;
          dest_idx_d     = '0;
          packet_valid_d = (fc_cur != 0);
          if (fc_cur != 0) packet_d = next_pkt;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (!packet_valid_q) begin
          state_d = RELEASE;
        end else if (packet_ready) begin
          if (int'(dest_idx_q) >= fc_cur - 1) begin
            packet_valid_d = 1'b0;
            state_d        = RELEASE;
          end else begin
            dest_idx_d = dest_idx_q + 1'b1;
            packet_d   = next_pkt;
          end
        end
      end
      RELEASE: begin
        release_mask = grant_oh_q;
        rr_ptr_d     = (grant_q == IDX_W'(N_NEURONS-1)) ? '0 : grant_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A spike on the source being released re-arms it instead of dropping.
    for (int i = 0; i < N_NEURONS; i++) begin
      if (spike[i] && pending_q[i] && !release_mask[i]) drops = drops + 1;
    end
    pending_d = (pending_q & ~release_mask) | spike;
    if (int'(drop_count_q) + drops > (1 << DROP_W) - 1) drop_count_d = '1;
    else drop_count_d = drop_count_q + DROP_W'(drops);
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      grant_oh_q     <= '0;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      dest_idx_q     <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      grant_oh_q     <= grant_oh_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      dest_idx_q     <= dest_idx_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = packet_valid_q;
  assign busy         = (state_q != IDLE);
  assign drop_count   = drop_count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spike_packet_scheduler.sv
// Bench for spike_packet_scheduler: scenario tasks plus a packet scoreboard
// that pops expected {origin, destination} words on every completed transfer.
module tb_spike_packet_scheduler;
  import spike_packet_scheduler_pkg::*;

  localparam int N  = 10;
  localparam int AW = 12;
  localparam int MF = 3;
  localparam int PW = 2 * AW;

  logic              CLK = 1'b0;
  logic              clear = 1'b1;
  logic [N-1:0]      spike = '0;
  logic [N*AW-1:0]   neuron_addresses = '0;
  logic [N*MF*AW-1:0] downstream_table = '0;
  logic [N*2-1:0]    fanout_count = '0;
  logic [PW-1:0]     packet;
  logic              packet_valid;
  logic              packet_ready = 1'b1;
  logic              busy;
  logic [7:0]        drop_count;
  sched_state_e      dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_exp;
  logic [1:0]    fc_model [N];

  spike_packet_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .MAX_FANOUT(MF)) dut (
    .CLK              (CLK),
    .clear            (clear),
    .spike            (spike),
    .neuron_addresses (neuron_addresses),
    .downstream_table (downstream_table),
    .fanout_count     (fanout_count),
    .packet           (packet),
    .packet_valid     (packet_valid),
    .packet_ready     (packet_ready),
    .busy             (busy),
    .drop_count       (drop_count),
    .dbg_state_o      (dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus model
  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(i);
  endfunction

  function automatic logic [AW-1:0] dest_of(input int i, input int j);
    if (i == 2) return AW'(16 + j);
    return AW'(64 + i * 256 + j);
  endfunction

  function automatic logic [N-1:0] bitm(input int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic expect_neuron(input int i);
    for (int j = 0; j < int'(fc_model[i]); j++) exp_q.push_back({addr_of(i), dest_of(i, j)});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 && n < budget) begin
      tick();
      n++;
      if (exp_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    tests_run++;
    if (quiet < 3) begin
      tests_failed++;
      $display("FAIL %s_drain: queue=%0d busy=%b after %0d cycles, required empty queue and idle",
               name, exp_q.size(), busy, n);
      exp_q.delete();
    end
  endtask

  // Scoreboard: a transfer completes at the next posedge when valid && ready
  always @(negedge CLK) begin
    if (!clear && packet_valid && packet_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_packet: got %h, required no packet", packet);
      end else begin
        mon_exp = exp_q.pop_front();
        if (packet !== mon_exp) begin
          tests_failed++;
          $display("FAIL packet_order: got %h, required %h", packet, mon_exp);
        end
      end
    end
  end

  // Scenarios
  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    tests_run += 5;
    if (packet_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", packet_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
    if (packet !== '0) begin tests_failed++; $display("FAIL reset_packet: got %h, required 0", packet); end
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_single();
    packet_ready = 1'b1;
    expect_neuron(2);
    spike = bitm(2);
    tick();
    spike = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      tests_run++;
      if (packet_valid !== 1'b1 || packet !== {addr_of(2), dest_of(2, j)}) begin
        tests_failed++;
        $display("FAIL single_pkt%0d: got valid=%b pkt=%h, required valid=1 pkt=%h",
                 j, packet_valid, packet, {addr_of(2), dest_of(2, j)});
      end
    end
    tick();
    tests_run++;
    if (packet_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_release: got valid=%b busy=%b, required valid=0 busy=1", packet_valid, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got busy=%b, required 0", busy); end
    wait_drain("single", 50);
  endtask

  task automatic test_round_robin();
    expect_neuron(5);
    spike = bitm(5);
    tick();
    spike = '0;
    wait_drain("rr_setup", 50);
    expect_neuron(9);
    expect_neuron(0);
    expect_neuron(5);
    spike = bitm(0) | bitm(5) | bitm(9);
    tick();
    spike = '0;
    wait_drain("rr_three", 100);
    // Pointer left at 6 means neuron 6 outranks neuron 5.
    expect_neuron(6);
    expect_neuron(5);
    spike = bitm(5) | bitm(6);
    tick();
    spike = '0;
    wait_drain("rr_ptr_end", 100);
  endtask

  task automatic test_stall();
    logic [PW-1:0] second;
    second = {addr_of(3), dest_of(3, 1)};
    expect_neuron(3);
    spike = bitm(3);
    tick();
    spike = '0;
    tick();
    tick();
    packet_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (packet_valid !== 1'b1 || packet !== second) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got valid=%b pkt=%h, required valid=1 pkt=%h",
                 c, packet_valid, packet, second);
      end
    end
    packet_ready = 1'b1;
    wait_drain("stall", 50);
  endtask

  task automatic test_zero_fanout();
    int seen;
    seen = 0;
    spike = bitm(4);
    tick();
    spike = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (packet_valid) seen++;
    end
    tests_run += 2;
    if (seen != 0) begin tests_failed++; $display("FAIL zero_fanout_valid: got %0d valid cycles, required 0", seen); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_fanout_done: got busy=%b, required 0", busy); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL zero_fanout_cleared: got %0d busy cycles, required 0", seen); end
  endtask

  task automatic test_drops();
    packet_ready = 1'b0;
    expect_neuron(3);
    spike = bitm(3);
    tick();
    spike = '0;
    tick();
    for (int r = 0; r < 3; r++) begin
      spike = bitm(1);
      tick();
      spike = '0;
      tick();
      if (r == 0) begin
        tests_run++;
        if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL drop_first: got %0d, required 0", drop_count); end
      end
    end
    tests_run++;
    if (drop_count !== 8'd2) begin tests_failed++; $display("FAIL drop_three: got %0d, required 2", drop_count); end
    spike = bitm(1);
    for (int c = 0; c < 260; c++) tick();
    spike = '0;
    tick();
    tests_run++;
    if (drop_count !== 8'd255) begin tests_failed++; $display("FAIL drop_saturate: got %0d, required 255", drop_count); end
    spike = bitm(1);
    tick();
    spike = '0;
    tick();
    tests_run++;
    if (drop_count !== 8'd255) begin tests_failed++; $display("FAIL drop_hold: got %0d, required 255", drop_count); end
    expect_neuron(1);
    packet_ready = 1'b1;
    wait_drain("drops", 100);
  endtask

  task automatic test_clear();
    packet_ready = 1'b0;
    spike = bitm(7);
    tick();
    spike = '0;
    tick();
    tests_run++;
    if (packet_valid !== 1'b1) begin tests_failed++; $display("FAIL clear_pre: got valid=%b, required 1", packet_valid); end
    clear = 1'b1;
    spike = bitm(8);
    tick();
    clear = 1'b0;
    spike = '0;
    tests_run += 3;
    if (packet_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_valid: got %b, required 0", packet_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy: got %b, required 0", busy); end
    if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL clear_drop: got %0d, required 0", drop_count); end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL clear_spike_ignored: got busy=%b, required 0", busy); end
    packet_ready = 1'b1;
    expect_neuron(0);
    expect_neuron(9);
    spike = bitm(0) | bitm(9);
    tick();
    spike = '0;
    wait_drain("clear_after", 100);
  endtask

  initial begin
    for (int i = 0; i < N; i++) fc_model[i] = 2'd3;
    fc_model[4] = 2'd0;
    for (int i = 0; i < N; i++) begin
      neuron_addresses[i*AW +: AW] = addr_of(i);
      fanout_count[i*2 +: 2] = fc_model[i];
      for (int j = 0; j < MF; j++) downstream_table[(i*MF+j)*AW +: AW] = dest_of(i, j);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_zero_fanout();
    test_drops();
    test_clear();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d outstanding packets, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
